// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage constants, response classification and PC helpers.
// Imported by if_fetch and if_fifo.
package if_fetch_pkg;

    localparam int INST_ADDR_BUS = 32;
    localparam int INST_BUS      = 64;
    localparam int IF_BUF_DEPTH  = 2;
    localparam int IF_PC_STEP    = 8;
    localparam logic [INST_ADDR_BUS-1:0] IF_RESET_PC = 32'h0000_0000;

    // How a memory response is consumed in the current cycle.
    typedef enum logic [1:0] {
        RSP_IGNORE,
        RSP_ACCEPT,
        RSP_DISCARD,
        RSP_DROP
    } rsp_action_e;

    function automatic logic pc_misaligned(input logic [2:0] low_bits);
        return low_bits != 3'b000;
    endfunction

endpackage

// File: rtl/if_fifo.sv
// Parameterised synchronous FIFO with async reset and a synchronous clear.
// The head entry is presented combinationally; push and pop may coincide.
module if_fifo
    import if_fetch_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: PC sequencing, in-order imem requests, {pc,inst} buffer.
// Optional build macro IF_ALIGN_CHK_EN adds a sticky misaligned-redirect fault.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_BUS,
    parameter int INST_W = INST_BUS,
    parameter int DEPTH  = IF_BUF_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IF_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] new_pc_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [INST_W-1:0] imem_rdata_i,
    output logic              inst_valid_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0] inst_o,
    input  logic              id_ready_i,
    output logic              fault_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = ADDR_W + INST_W;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] flush_target;
    logic [ADDR_W-1:0] pcq_head;
    logic [CNT_W-1:0]  pcq_count;
    logic [CNT_W-1:0]  buf_count;
    logic [CNT_W-1:0]  drop;
    logic [CNT_W-1:0]  drop_next;
    logic [CNT_W:0]    occupancy;
    logic              pcq_full;
    logic              pcq_empty;
    logic              buf_full;
    logic              buf_empty;
    logic [ENT_W-1:0]  buf_head;
    logic [ENT_W-1:0]  last_entry;
    logic              room;
    logic              fetch_block;
    logic              issue;
    logic              transfer;
    logic              rsp_accept;
    rsp_action_e       rsp_action;

    // The in-flight PC queue occupancy doubles as the outstanding-request count.
    assign occupancy    = {1'b0, buf_count} + {1'b0, pcq_count};
    assign room         = !buf_full && !pcq_full && (occupancy < (CNT_W+1)'(DEPTH));
    assign imem_req_o   = !rst && !flush_i && !fetch_block && room;
    assign imem_addr_o  = fetch_pc;
    assign issue        = imem_req_o && imem_gnt_i;
    assign inst_valid_o = !buf_empty;
    assign transfer     = inst_valid_o && id_ready_i;
    assign rsp_accept   = (rsp_action == RSP_ACCEPT);

    // Stale responses from before a flush are consumed ahead of any live ones.
    always_comb begin
        rsp_action = RSP_IGNORE;
        if (imem_rvalid_i) begin
            if (drop != '0) begin
                rsp_action = RSP_DROP;
            end else if (!pcq_empty) begin
                rsp_action = flush_i ? RSP_DISCARD : RSP_ACCEPT;
            end
        end
    end

    always_comb begin
        drop_next = drop;
        if (flush_i) begin
            drop_next = drop + pcq_count;
            if (rsp_action == RSP_DROP || rsp_action == RSP_DISCARD) begin
                drop_next = drop + pcq_count - CNT_W'(1);
            end
        end else if (rsp_action == RSP_DROP) begin
            drop_next = drop - CNT_W'(1);
        end
    end

`ifdef IF_ALIGN_CHK_EN
    logic fault;

    assign flush_target = {new_pc_i[ADDR_W-1:3], 3'b000};
    assign fetch_block  = fault;
    assign fault_o      = fault;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault <= 1'b0;
        end else if (flush_i) begin
            fault <= pc_misaligned(new_pc_i[2:0]);
        end
    end
`else
    assign flush_target = new_pc_i;
    assign fetch_block  = 1'b0;
    assign fault_o      = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            drop     <= '0;
        end else begin
            drop <= drop_next;
            if (flush_i) begin
                fetch_pc <= flush_target;
            end else if (issue) begin
                fetch_pc <= fetch_pc + ADDR_W'(IF_PC_STEP);
            end
        end
    end

    // Holds the most recently transferred entry so the outputs are stable when empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_entry <= '0;
        end else if (transfer) begin
            last_entry <= buf_head;
        end
    end

    assign {pc_o, inst_o} = buf_empty ? last_entry : buf_head;

    if_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (DEPTH)
    ) u_pc_queue (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush_i),
        .push      (issue),
        .push_data (fetch_pc),
        .pop       (rsp_accept),
        .head      (pcq_head),
        .count     (pcq_count),
        .full      (pcq_full),
        .empty     (pcq_empty)
    );

    if_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_inst_buf (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush_i),
        .push      (rsp_accept),
        .push_data ({pcq_head, imem_rdata_i}),
        .pop       (transfer),
        .head      (buf_head),
        .count     (buf_count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: queue-based reference model, in-order memory model,
// directed scenarios followed by randomized traffic. Follows IF_ALIGN_CHK_EN if defined.
module tb_if_fetch;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic [31:0] new_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [63:0] imem_rdata_i = '0;
    logic        inst_valid_o;
    logic [31:0] pc_o;
    logic [63:0] inst_o;
    logic        id_ready_i = 1'b0;
    logic        fault_o;

    if_fetch #(
        .ADDR_W   (32),
        .INST_W   (64),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .new_pc_i      (new_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .inst_valid_o  (inst_valid_o),
        .pc_o          (pc_o),
        .inst_o        (inst_o),
        .id_ready_i    (id_ready_i),
        .fault_o       (fault_o)
    );

    always #5 clk = ~clk;

    // Reference model state: decode-bound entries, live in-flight PCs, stale responses owed.
    logic [31:0] buf_q[$];
    logic [31:0] inflight_q[$];
    logic [31:0] mem_addr_q[$];
    int          mem_rdy_q[$];
    logic [31:0] xfer_log[$];
    logic [31:0] m_pc;
    logic        m_fault;
    int          m_drop;
    int          cyc;
    int          issues_seen;
    int          checks;
    int          failures;

    function automatic logic [63:0] tag(input logic [31:0] a);
        return {~a, a ^ 32'h5A5A_0F0F};
    endfunction

    task automatic check_output(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        buf_q.delete();
        inflight_q.delete();
        mem_addr_q.delete();
        mem_rdy_q.delete();
        xfer_log.delete();
        m_pc    = RESET_PC;
        m_fault = 1'b0;
        m_drop  = 0;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        flush_i       = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        id_ready_i    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic apply_stimulus(input logic fl, input logic [31:0] npc, input logic g,
                                  input logic rdy, input int lat);
        logic        rsp;
        logic        exp_req;
        logic        exp_valid;
        logic        issue;
        logic        xfer;
        logic [31:0] req_addr;
        flush_i    = fl;
        new_pc_i   = npc;
        imem_gnt_i = g;
        id_ready_i = rdy;
        rsp = (mem_addr_q.size() > 0) && (mem_rdy_q[0] <= cyc);
        imem_rvalid_i = rsp;
        imem_rdata_i  = rsp ? tag(mem_addr_q[0]) : {$urandom, $urandom};
        #1;
        exp_req   = !fl && !m_fault && (buf_q.size() + inflight_q.size() < DEPTH);
        exp_valid = (buf_q.size() != 0);
        check_output("imem_req", imem_req_o, exp_req);
        check_output("imem_addr", imem_addr_o, m_pc);
        check_output("inst_valid", inst_valid_o, exp_valid);
        check_output("fault", fault_o, m_fault);
        if (exp_valid) begin
            check_output("pc_o", pc_o, buf_q[0]);
            check_output("inst_o", inst_o, tag(buf_q[0]));
        end
        issue    = exp_req && g;
        xfer     = exp_valid && rdy;
        req_addr = imem_addr_o;
        if (xfer) begin
            xfer_log.push_back(buf_q.pop_front());
        end
        if (rsp) begin
            void'(mem_addr_q.pop_front());
            void'(mem_rdy_q.pop_front());
            if (m_drop > 0) begin
                m_drop--;
            end else if (inflight_q.size() > 0) begin
                if (fl) void'(inflight_q.pop_front());
                else    buf_q.push_back(inflight_q.pop_front());
            end
        end
        if (issue) begin
            issues_seen++;
            inflight_q.push_back(m_pc);
            mem_addr_q.push_back(req_addr);
            mem_rdy_q.push_back(cyc + lat);
            m_pc = m_pc + 32'd8;
        end
        if (fl) begin
            m_drop += inflight_q.size();
            inflight_q.delete();
            buf_q.delete();
            xfer_log.delete();
`ifdef IF_ALIGN_CHK_EN
            m_fault = (npc[2:0] != 3'b000);
            m_pc    = {npc[31:3], 3'b000};
`else
            m_pc    = npc;
`endif
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_cycles(input int n, input logic g, input logic rdy, input int lat);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(1'b0, 32'h0, g, rdy, lat);
        end
    endtask

    initial begin
        logic [31:0] held_addr;
        cyc = 0; checks = 0; failures = 0; issues_seen = 0;
        model_reset();

        #1;
        check_output("reset_req", imem_req_o, 1'b0);
        check_output("reset_addr", imem_addr_o, RESET_PC);
        check_output("reset_valid", inst_valid_o, 1'b0);
        check_output("reset_pc", pc_o, 32'h0);
        check_output("reset_inst", inst_o, 64'h0);
        check_output("reset_fault", fault_o, 1'b0);
        @(negedge clk);
        do_reset();

        // Streaming with a 1-cycle memory; sequence must start 0x0,0x8,0x10.
        run_cycles(20, 1'b1, 1'b1, 1);
        check_output("stream_pc0", xfer_log[0], 32'h0);
        check_output("stream_pc1", xfer_log[1], 32'h8);
        check_output("stream_pc2", xfer_log[2], 32'h10);

        // Decode stalled from reset: exactly DEPTH requests, then none.
        do_reset();
        issues_seen = 0;
        run_cycles(5, 1'b1, 1'b0, 1);
        check_output("stall_issues", 32'(issues_seen), 32'(DEPTH));
        check_output("stall_req_low", imem_req_o, 1'b0);
        run_cycles(10, 1'b1, 1'b1, 1);
        check_output("drain_pc0", xfer_log[0], 32'h0);
        check_output("drain_pc1", xfer_log[1], 32'h8);
        check_output("drain_pc2", xfer_log[2], 32'h10);

        // Grant withheld: address must not move.
        held_addr = imem_addr_o;
        run_cycles(3, 1'b0, 1'b1, 1);
        check_output("gnt_hold_addr", imem_addr_o, held_addr);

        // Two outstanding on a slow memory, then redirect to 0x100.
        run_cycles(6, 1'b0, 1'b1, 1);
        run_cycles(2, 1'b1, 1'b0, 3);
        check_output("pre_flush_outstanding", 32'(inflight_q.size()), 32'd2);
        apply_stimulus(1'b1, 32'h100, 1'b1, 1'b1, 3);
        check_output("post_flush_valid", inst_valid_o, 1'b0);
        run_cycles(12, 1'b1, 1'b1, 1);
        check_output("flush_first_pc", xfer_log[0], 32'h100);

        // Misaligned redirect followed by an aligned one.
        run_cycles(6, 1'b0, 1'b1, 1);
        apply_stimulus(1'b1, 32'h104, 1'b0, 1'b1, 1);
`ifdef IF_ALIGN_CHK_EN
        check_output("misalign_fault", fault_o, 1'b1);
        check_output("misalign_addr", imem_addr_o, 32'h100);
`else
        check_output("misalign_fault", fault_o, 1'b0);
        check_output("misalign_addr", imem_addr_o, 32'h104);
`endif
        run_cycles(3, 1'b1, 1'b1, 1);
        run_cycles(6, 1'b0, 1'b1, 1);
        apply_stimulus(1'b1, 32'h200, 1'b0, 1'b1, 1);
        check_output("realign_fault", fault_o, 1'b0);
        check_output("realign_addr", imem_addr_o, 32'h200);
        run_cycles(8, 1'b1, 1'b1, 1);
        check_output("realign_first_pc", xfer_log[0], 32'h200);

        // Randomized traffic; redirects only while the memory owes at most DEPTH responses.
        for (int i = 0; i < 600; i++) begin
            logic        fl;
            logic [31:0] npc;
            fl  = ($urandom_range(0, 15) == 0) && (mem_addr_q.size() <= DEPTH);
            npc = 32'($urandom_range(0, 4095)) << 3;
            apply_stimulus(fl, npc, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                           $urandom_range(1, 4));
        end

        // Asynchronous reset in the middle of a response stream.
        run_cycles(4, 1'b1, 1'b1, 2);
        #2;
        rst = 1'b1;
        #1;
        check_output("async_rst_req", imem_req_o, 1'b0);
        check_output("async_rst_addr", imem_addr_o, RESET_PC);
        check_output("async_rst_valid", inst_valid_o, 1'b0);
        check_output("async_rst_pc", pc_o, 32'h0);
        check_output("async_rst_inst", inst_o, 64'h0);
        check_output("async_rst_fault", fault_o, 1'b0);
        @(negedge clk);
        do_reset();
        flush_i = 1'b0;
        #1;
        check_output("post_rst_req", imem_req_o, 1'b1);
        check_output("post_rst_addr", imem_addr_o, RESET_PC);
        @(negedge clk);
        run_cycles(10, 1'b1, 1'b1, 1);
        check_output("post_rst_first_pc", xfer_log[0], RESET_PC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
